matvec3_part2: RTL and testbench



---
 rtl/matvec3_pkg.sv | 23 ++
 rtl/matvec3_mac.sv | 45 ++++
 rtl/matvec3_part2.sv | 160 ++++++++++++++++
 tb/tb_matvec3_part2.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/matvec3_pkg.sv
// matvec3_pkg: shared widths, FSM state encoding and matrix index helper
// for the streaming 3x3 matrix-vector multiplier.
//   IN_W  : input word width (signed)
//   OUT_W : result width (signed, wraps on overflow)
//   N     : matrix/vector dimension
package matvec3_pkg;

  localparam int IN_W  = 14;
  localparam int OUT_W = 28;
  localparam int N     = 3;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_e;

  // Row-major flat index of M[row][col] (3*row + col).
  function automatic logic [3:0] mat_idx(input logic [1:0] row, input logic [1:0] col);
    return (4'd3 * {2'b00, row}) + {2'b00, col};
  endfunction

endpackage

// File: rtl/matvec3_mac.sv
// matvec3_mac: 14x14 signed multiply with a 28-bit wrapping accumulator.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   en         : update the accumulator with sum this cycle
//   clear      : start a new dot product (ignore the stored accumulator)
//   a, b       : signed operands
//   sum        : combinational next accumulator value
module matvec3_mac
  import matvec3_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    clear,
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  output logic        [OUT_W-1:0] sum
);

  logic signed [OUT_W-1:0] prod_s;
  logic        [OUT_W-1:0] acc_r;

  // Both operands are signed, so they are sign-extended to the full product width.
  assign prod_s = a * b;

  // Next accumulator value: clear restarts from zero; carries out of bit 27 are dropped.
  always_comb begin
    sum = {OUT_W{1'b0}};
    if (clear) begin
      sum = prod_s;
    end else begin
      sum = acc_r + prod_s;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r <= {OUT_W{1'b0}};
    end else if (en) begin
      acc_r <= sum;
    end
  end

endmodule

// File: rtl/matvec3_part2.sv
// matvec3_part2: streaming 3x3 signed matrix x 3-vector multiplier with a
// stored, reusable matrix.
// Ports:
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   input_valid   : producer offers input_data/new_matrix
//   input_ready   : block accepts a word (LOAD state, not in reset)
//   input_data    : signed 14-bit word
//   new_matrix    : on the first word of a group, 1 = 9 matrix words then 3 vector words
//   output_valid  : output_data holds y[k]
//   output_ready  : consumer accepts y[k]
//   output_data   : signed 28-bit result, emitted y[0], y[1], y[2]
module matvec3_part2
  import matvec3_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             input_valid,
  output logic             input_ready,
  input  logic [IN_W-1:0]  input_data,
  input  logic             new_matrix,
  output logic             output_valid,
  input  logic             output_ready,
  output logic [OUT_W-1:0] output_data
);

  state_e                  state_r;
  logic        [3:0]       word_cnt_r;
  logic        [1:0]       k_r;
  logic        [1:0]       c_r;
  logic signed [IN_W-1:0]  m_r [0:N*N-1];
  logic signed [IN_W-1:0]  x_r [0:N-1];
  logic                    output_valid_r;
  logic        [OUT_W-1:0] output_data_r;

  logic                    in_fire_s;
  logic                    out_fire_s;
  logic        [3:0]       eff_idx_s;
  logic signed [IN_W-1:0]  mac_a_s;
  logic signed [IN_W-1:0]  mac_b_s;
  logic                    mac_en_s;
  logic                    mac_clear_s;
  logic        [OUT_W-1:0] mac_sum_s;

  assign input_ready  = (state_r == LOAD) && !reset;
  assign in_fire_s    = input_valid && input_ready;
  assign out_fire_s   = output_valid_r && output_ready;
  assign output_valid = output_valid_r;
  assign output_data  = output_data_r;

  // Slot of the current word in a 12-word frame (0-8 matrix, 9-11 vector).
  // A vector-only group starts directly at slot 9, so one counter serves both group types.
  always_comb begin
    eff_idx_s = word_cnt_r;
    if ((word_cnt_r == 4'd0) && !new_matrix) begin
      eff_idx_s = 4'd9;
    end else begin
      eff_idx_s = word_cnt_r;
    end
  end

  // MAC operand selection for term M[k][c] * x[c].
  always_comb begin
    mac_a_s = m_r[mat_idx(k_r, c_r)];
    case (c_r)
      2'd0:    mac_b_s = x_r[0];
      2'd1:    mac_b_s = x_r[1];
      default: mac_b_s = x_r[2];
    endcase
  end

  assign mac_en_s    = (state_r == COMPUTE);
  assign mac_clear_s = (c_r == 2'd0);

  matvec3_mac u_mac (
    .clk   (clk),
    .reset (reset),
    .en    (mac_en_s),
    .clear (mac_clear_s),
    .a     (mac_a_s),
    .b     (mac_b_s),
    .sum   (mac_sum_s)
  );

  // Matrix and vector register files, written on each accepted word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N*N; i++) begin
        m_r[i] <= {IN_W{1'b0}};
      end
      for (int i = 0; i < N; i++) begin
        x_r[i] <= {IN_W{1'b0}};
      end
    end else if (in_fire_s) begin
      case (eff_idx_s)
        4'd9:    x_r[0] <= input_data;
        4'd10:   x_r[1] <= input_data;
        4'd11:   x_r[2] <= input_data;
        default: begin
          if (eff_idx_s < 4'd9) begin
            m_r[eff_idx_s] <= input_data;
          end
        end
      endcase
    end
  end

  // Control FSM: word counter, row/column counters and registered output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= LOAD;
      word_cnt_r     <= 4'd0;
      k_r            <= 2'd0;
      c_r            <= 2'd0;
      output_valid_r <= 1'b0;
      output_data_r  <= {OUT_W{1'b0}};
    end else begin
      case (state_r)
        LOAD: begin
          if (in_fire_s) begin
            if (eff_idx_s == 4'd11) begin
              state_r    <= COMPUTE;
              word_cnt_r <= 4'd0;
              k_r        <= 2'd0;
              c_r        <= 2'd0;
            end else begin
              word_cnt_r <= eff_idx_s + 4'd1;
            end
          end
        end
        COMPUTE: begin
          if (c_r == 2'd2) begin
            state_r        <= OUTPUT;
            c_r            <= 2'd0;
            output_valid_r <= 1'b1;
            output_data_r  <= mac_sum_s;
          end else begin
            c_r <= c_r + 2'd1;
          end
        end
        OUTPUT: begin
          if (out_fire_s) begin
            output_valid_r <= 1'b0;
            if (k_r == 2'd2) begin
              state_r    <= LOAD;
              k_r        <= 2'd0;
              word_cnt_r <= 4'd0;
            end else begin
              state_r <= COMPUTE;
              k_r     <= k_r + 2'd1;
            end
          end
        end
        default: begin
          state_r <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matvec3_part2.sv
// Testbench for matvec3_part2: directed test-plan steps plus randomized groups
// with input/output stalls, checked against an arithmetic reference model.
module tb_matvec3_part2;

  logic        clk = 1'b0;
  logic        reset;
  logic        input_valid;
  logic        input_ready;
  logic [13:0] input_data;
  logic        new_matrix;
  logic        output_valid;
  logic        output_ready;
  logic [27:0] output_data;

  int          vectors = 0;
  int          miscompares = 0;

  // Reference model state: stored matrix (row-major) and current vector.
  int          gm [9];
  int          gx [3];
  int          words [12];
  logic [27:0] obs [3];
  bit          stall_en;

  matvec3_part2 dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .new_matrix   (new_matrix),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [27:0] exp28(input int v);
    return v[27:0];
  endfunction

  // y[k] = sum_c M[k][c]*x[c], wrapped to 28 bits.
  function automatic logic [27:0] model_y(input int k);
    longint s = 0;
    for (int c = 0; c < 3; c++) s += longint'(gm[3*k+c]) * longint'(gx[c]);
    return s[27:0];
  endfunction

  task automatic send_group(input bit nm);
    int n = nm ? 12 : 3;
    for (int i = 0; i < n; i++) begin
      if (nm && i < 9) gm[i] = words[i];
      else gx[i - (nm ? 9 : 0)] = words[i];
    end
    for (int i = 0; i < n; i++) begin
      int w = words[i];
      int t = 0;
      if (stall_en) begin
        repeat ($urandom_range(0, 2)) begin
          input_valid = 1'b0;
          input_data  = 'x;
          new_matrix  = 'x;
          @(negedge clk);
        end
      end
      input_valid = 1'b1;
      input_data  = w[13:0];
      new_matrix  = (i == 0) ? nm : 1'($urandom_range(0, 1));
      while (input_ready !== 1'b1 && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t == 50) check("input_ready_timeout", {31'b0, input_ready}, 32'd1);
      @(negedge clk);
    end
    input_valid = 1'b0;
    input_data  = 'x;
    new_matrix  = 'x;
  endtask

  // Called just after the transfer edge T: output_valid low for T..T+2, high from T+3.
  task automatic latency(input string tag);
    check({tag, "_lat0"}, {31'b0, output_valid}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check({tag, "_lat0"}, {31'b0, output_valid}, 32'd0);
    end
    @(negedge clk);
    check({tag, "_lat3"}, {31'b0, output_valid}, 32'd1);
  endtask

  task automatic receive(input int n_accept);
    for (int k = 0; k < n_accept; k++) begin
      logic [27:0] e = model_y(k);
      if (stall_en) begin
        repeat ($urandom_range(0, 3)) begin
          check("stall_valid", {31'b0, output_valid}, 32'd1);
          check("stall_data", {4'b0, output_data}, {4'b0, e});
          @(negedge clk);
        end
      end
      output_ready = 1'b1;
      check("out_valid", {31'b0, output_valid}, 32'd1);
      check("out_data", {4'b0, output_data}, {4'b0, e});
      obs[k] = output_data;
      @(negedge clk);
      output_ready = 1'b0;
      if (k < 2) begin
        latency("next_y");
      end else begin
        check("done_valid", {31'b0, output_valid}, 32'd0);
        check("done_ready", {31'b0, input_ready}, 32'd1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    input_valid  = 1'b0;
    input_data   = 14'd0;
    new_matrix   = 1'b0;
    output_ready = 1'b0;
    stall_en     = 1'b0;
    for (int i = 0; i < 9; i++) gm[i] = 0;
    for (int i = 0; i < 3; i++) gx[i] = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", {31'b0, output_valid}, 32'd0);
    check("rst_data", {4'b0, output_data}, 32'd0);
    check("rst_ready", {31'b0, input_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", {31'b0, input_ready}, 32'd1);
    @(negedge clk);

    // Matrix plus vector
    words = '{10, -20, 30, 50, -60, 70, 80, 100, -110, 40, 30, -20};
    send_group(1'b1);
    latency("t1");
    receive(3);
    check("t1_y0", {4'b0, obs[0]}, {4'b0, exp28(-800)});
    check("t1_y1", {4'b0, obs[1]}, {4'b0, exp28(-1200)});
    check("t1_y2", {4'b0, obs[2]}, {4'b0, exp28(8400)});

    // Vector-only reuse of stored matrix
    words[0] = 50; words[1] = -60; words[2] = -70;
    send_group(1'b0);
    latency("t2");
    receive(3);
    check("t2_y0", {4'b0, obs[0]}, {4'b0, exp28(-400)});
    check("t2_y1", {4'b0, obs[1]}, {4'b0, exp28(1200)});
    check("t2_y2", {4'b0, obs[2]}, {4'b0, exp28(5700)});

    // Idle after completion
    repeat (100) begin
      @(negedge clk);
      check("idle_valid", {31'b0, output_valid}, 32'd0);
      check("idle_ready", {31'b0, input_ready}, 32'd1);
    end

    // Randomized groups with input and output stalls
    stall_en = 1'b1;
    for (int g = 0; g < 12; g++) begin
      bit nm = (g % 3 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < 12; i++) words[i] = int'($urandom_range(0, 16383)) - 8192;
      send_group(nm);
      latency("rnd");
      receive(3);
    end
    stall_en = 1'b0;

    // Overflow wrap of the 28-bit accumulator
    for (int i = 0; i < 12; i++) words[i] = int'($urandom_range(0, 16383)) - 8192;
    words[0] = -8192; words[1] = -8192; words[2] = -8192;
    words[9] = -8192; words[10] = -8192; words[11] = -8192;
    send_group(1'b1);
    latency("ovf");
    receive(3);
    check("ovf_y0", {4'b0, obs[0]}, {4'b0, exp28(-67108864)});

    // Reset while y[1] is being offered
    for (int i = 0; i < 12; i++) words[i] = int'($urandom_range(1, 2000));
    send_group(1'b1);
    latency("rst_mid");
    receive(1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", {31'b0, output_valid}, 32'd0);
    check("rst_mid_ready", {31'b0, input_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_mid_ready_after", {31'b0, input_ready}, 32'd1);
    for (int i = 0; i < 9; i++) gm[i] = 0;
    @(negedge clk);
    words[0] = 1; words[1] = 2; words[2] = 3;
    send_group(1'b0);
    latency("rst_vec");
    receive(3);
    check("rst_vec_y0", {4'b0, obs[0]}, 32'd0);
    check("rst_vec_y1", {4'b0, obs[1]}, 32'd0);
    check("rst_vec_y2", {4'b0, obs[2]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
